// File: rtl/cambio_dispenser.sv
// Change-coin hopper controller: latches the change owed on a vend event and pays it out
// greedily, one coin per request/acknowledge handshake, with an acknowledge timeout.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | waiting for start; done pulses here after a payout or zero change
// S_EJECT | one eject line held, waiting for coin_ack or timeout
// S_GAP   | one hopper-recovery cycle between coins, no eject asserted
// S_FAULT | hopper stalled; sticky until reset
module cambio_dispenser #(
    parameter int unsigned DENOM_HI    = 2,
    parameter int unsigned DENOM_LO    = 1,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cambio,
    input  logic       coin_ack,
    output logic       eject_hi,
    output logic       eject_lo,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] remaining
);

    localparam logic [3:0] DHI = 4'(DENOM_HI);
    localparam logic [3:0] DLO = 4'(DENOM_LO);
    localparam logic [3:0] TMO = 4'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EJECT = 2'd1,
        S_GAP   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic [3:0] cnt_q, cnt_d;
    logic       eject_hi_q, eject_hi_d;
    logic       eject_lo_q, eject_lo_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fault_q, fault_d;
    logic [3:0] denom;
    logic [3:0] cnt_inc;

    always_comb begin
        denom   = eject_hi_q ? DHI : DLO;
        cnt_inc = cnt_q + 4'd1;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        eject_hi_d  = eject_hi_q;
        eject_lo_d  = eject_lo_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fault_d     = fault_q;

        case (state_q)
            S_IDLE: begin
                eject_hi_d = 1'b0;
                eject_lo_d = 1'b0;
                busy_d     = 1'b0;
                cnt_d      = '0;
                if (start) begin
                    remaining_d = cambio;
                    if (cambio == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = S_EJECT;
                        busy_d     = 1'b1;
                        eject_hi_d = (cambio >= DHI);
                        eject_lo_d = (cambio < DHI);
                    end
                end
            end
            S_EJECT: begin
                // An ack landing in the timeout cycle still counts as a paid coin.
                if (coin_ack) begin
                    if (remaining_q >= denom) begin
                        remaining_d = remaining_q - denom;
                    end
                    eject_hi_d = 1'b0;
                    eject_lo_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_GAP;
                end else if (cnt_inc >= TMO) begin
                    eject_hi_d = 1'b0;
                    eject_lo_d = 1'b0;
                    fault_d    = 1'b1;
                    cnt_d      = cnt_inc;
                    state_d    = S_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                if (remaining_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    eject_hi_d = (remaining_q >= DHI);
                    eject_lo_d = (remaining_q < DHI);
                    state_d    = S_EJECT;
                end
            end
            S_FAULT: begin
                eject_hi_d = 1'b0;
                eject_lo_d = 1'b0;
                busy_d     = 1'b1;
                fault_d    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            cnt_q       <= '0;
            eject_hi_q  <= 1'b0;
            eject_lo_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            eject_hi_q  <= eject_hi_d;
            eject_lo_q  <= eject_lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    assign eject_hi  = eject_hi_q;
    assign eject_lo  = eject_lo_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_cambio_dispenser.sv
// Bench for cambio_dispenser: a hopper model answers eject requests with scripted delays,
// and a monitor checks every coin request, done pulse and fault against a scoreboard queue.
module tb_cambio_dispenser;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] cambio;
    logic       coin_ack;
    logic       eject_hi;
    logic       eject_lo;
    logic       busy;
    logic       done;
    logic       fault;
    logic [3:0] remaining;

    cambio_dispenser dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cambio    (cambio),
        .coin_ack  (coin_ack),
        .eject_hi  (eject_hi),
        .eject_lo  (eject_lo),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int EV_HI = 1, EV_LO = 2, EV_DONE = 3, EV_FAULT = 4;

    typedef struct {
        int kind;
        int rem;
    } ev_t;

    ev_t exp_q[$];
    int  delay_q[$];
    int  total = 0;
    int  bad   = 0;
    bit  gap_ack = 0;
    bit  spur = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int k, input int r);
        ev_t e;
        e.kind = k;
        e.rem  = r;
        exp_q.push_back(e);
    endtask

    // Reference payout: greedy coins of 2 then 1; a coin whose ack would come later than
    // the 15th request cycle stalls the hopper.
    task automatic model(input int c, output bit faults);
        int r;
        int i;
        int d;
        int dl;
        r = c;
        i = 0;
        faults = 0;
        while (r > 0) begin
            d = (r >= 2) ? 2 : 1;
            push_ev((d == 2) ? EV_HI : EV_LO, r);
            dl = (i < delay_q.size()) ? delay_q[i] : 1000;
            if (dl >= 15) begin
                push_ev(EV_FAULT, r);
                faults = 1;
                return;
            end
            r -= d;
            i++;
        end
        push_ev(EV_DONE, 0);
    endtask

    // Hopper: acks in request cycle delay+1; optionally holds ack into the GAP cycle.
    initial begin
        int  wait_cnt;
        bit  hold;
        coin_ack = 1'b0;
        wait_cnt = -1;
        hold     = 0;
        forever begin
            @(negedge clk);
            coin_ack = spur | hold;
            hold     = 0;
            if (eject_hi || eject_lo) begin
                if (wait_cnt < 0) begin
                    wait_cnt = (delay_q.size() > 0) ? delay_q.pop_front() : 1000;
                end
                if (wait_cnt == 0) begin
                    coin_ack = 1'b1;
                    hold     = gap_ack;
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end else begin
                wait_cnt = -1;
            end
        end
    end

    task automatic got(input int k, input int r);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind=%0d rem=%0d, expected no event at %0t", k, r, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_rem", r, e.rem);
        end
    endtask

    initial begin
        bit prev_hi, prev_lo, prev_fault;
        prev_hi    = 0;
        prev_lo    = 0;
        prev_fault = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("eject_exclusive", int'(eject_hi & eject_lo), 0);
                if (eject_hi && !prev_hi) got(EV_HI, int'(remaining));
                if (eject_lo && !prev_lo) got(EV_LO, int'(remaining));
                if (done) got(EV_DONE, int'(remaining));
                if (fault && !prev_fault) got(EV_FAULT, int'(remaining));
            end
            prev_hi    = eject_hi;
            prev_lo    = eject_lo;
            prev_fault = fault;
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        delay_q.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("reset_outputs", int'({eject_hi, eject_lo, busy, done, fault, remaining}), 0);
    endtask

    task automatic do_start(input int c);
        @(negedge clk);
        start  = 1'b1;
        cambio = 4'(c);
        @(negedge clk);
        start  = 1'b0;
        cambio = 4'($urandom_range(0, 15));
        if (c == 0) begin
            chk("zero_done", int'(done), 1);
            chk("zero_busy", int'(busy), 0);
        end else begin
            chk("latency_busy", int'(busy), 1);
            chk("latency_hi", int'(eject_hi), int'(c >= 2));
            chk("latency_lo", int'(eject_lo), int'(c < 2));
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && (!busy || fault)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_idle_timeout: pending=%0d busy=%0d, expected drained", exp_q.size(), busy);
        end
    endtask

    initial begin
        bit flt;
        int c;
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        cambio = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_outputs", int'({eject_hi, eject_lo, busy, done, fault, remaining}), 0);

        // 5 -> hi, hi, lo with acks in request cycle 3
        delay_q = '{2, 2, 2};
        model(5, flt);
        do_start(5);
        wait_idle();
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_remaining", int'(remaining), 0);

        // zero change
        model(0, flt);
        do_start(0);
        @(negedge clk);
        chk("t2_done_width", int'(done), 0);
        chk("t2_busy", int'(busy), 0);

        // hopper never acks
        delay_q.delete();
        model(1, flt);
        do_start(1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!eject_lo) break;
            n++;
        end
        chk("t3_eject_cycles", n, 15);
        chk("t3_fault", int'(fault), 1);
        chk("t3_busy", int'(busy), 1);
        chk("t3_remaining", int'(remaining), 1);
        @(negedge clk);
        start  = 1'b1;
        cambio = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_start_ignored", int'({eject_hi, eject_lo, fault, remaining}), 'h11);
        reset_dut();

        // second start during dispense is ignored
        delay_q = '{3, 3};
        model(4, flt);
        do_start(4);
        start  = 1'b1;
        cambio = 4'd9;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("t4_remaining", int'(remaining), 0);

        // reset in the second request cycle
        delay_q = '{1000};
        push_ev(EV_HI, 6);
        do_start(6);
        reset_dut();
        delay_q = '{0};
        model(2, flt);
        do_start(2);
        wait_idle();
        chk("t5_remaining", int'(remaining), 0);

        // stray acks in IDLE and GAP; ack on the last allowed request cycle
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_idle_ack", int'({busy, eject_hi, eject_lo, remaining}), 0);
        gap_ack = 1;
        delay_q = '{14, 0, 1};
        model(5, flt);
        do_start(5);
        wait_idle();
        chk("t6_no_fault", int'(fault), 0);
        gap_ack = 0;

        for (int it = 0; it < 30; it++) begin
            c = $urandom_range(0, 15);
            delay_q.delete();
            for (int k = 0; k < 8; k++) begin
                delay_q.push_back(($urandom_range(0, 11) == 0) ? 15 + $urandom_range(0, 3)
                                                               : $urandom_range(0, 14));
            end
            gap_ack = $urandom_range(0, 1);
            model(c, flt);
            do_start(c);
            wait_idle();
            if (flt) begin
                chk("rand_fault", int'(fault), 1);
                reset_dut();
            end else begin
                chk("rand_remaining", int'(remaining), 0);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cambio_dispenser.md
Name: cambio_dispenser

Overview:
Downstream consumer of the vending FSM pair's change value (cambio, 4-bit). On a vend event it latches the change owed and drives a coin hopper, issuing one coin at a time with a request/acknowledge handshake. It uses greedy denomination selection, detects hopper stalls via an acknowledge timeout, and reports progress on uo[7:6]-class status lines.

Parameters:
DENOM_HI, 2, value of large change coin (units of total/cambio)
DENOM_LO, 1, value of small change coin; must divide any residue, fixed at 1 for full coverage
ACK_TIMEOUT, 15, max cycles eject may stay high without coin_ack before FAULT (4-bit counter)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  vend event pulse (vendA | vendB); samples cambio
cambio  input  4  change owed, valid in the cycle start is high
coin_ack  input  1  hopper acknowledge: requested coin physically dispensed
eject_hi  output  1  request one DENOM_HI coin; held until ack
eject_lo  output  1  request one DENOM_LO coin; held until ack
busy  output  1  high from start acceptance until done/fault
done  output  1  one-cycle pulse when remaining reaches 0
fault  output  1  sticky hopper-timeout flag
remaining  output  4  change still owed

Behaviour:
- Reset (sync, active-high): state IDLE; eject_hi=eject_lo=busy=done=fault=0; remaining=0; timeout counter=0. Reset mid-dispense aborts immediately; the next cycle shows all outputs 0.
- States: IDLE, EJECT, GAP, FAULT.
- IDLE: on start=1, remaining<=cambio.
  - If cambio==0: done=1 for the next cycle and state stays IDLE (busy stays 0).
  - Else: next cycle is EJECT with busy=1 and exactly one eject asserted: eject_hi if cambio>=DENOM_HI, otherwise eject_lo. Latency start->eject = 1 cycle.
- EJECT: the eject line is held constant. The timeout counter increments each cycle coin_ack=0.
  - On coin_ack=1: remaining<=remaining-denom, eject deasserts, counter clears, next state GAP.
  - If the counter reaches ACK_TIMEOUT with no ack: next state FAULT.
  - If ack and timeout coincide, ack wins.
- GAP: one cycle with both ejects 0 (hopper recovery).
  - If remaining==0: next cycle done=1, busy=0, state IDLE.
  - Else: next cycle EJECT, with denomination re-chosen greedily from remaining.
- FAULT: fault=1, busy=1, ejects 0, remaining frozen. Exit only via reset.
- Greedy rule: remaining>=DENOM_HI gives hi coin, otherwise lo coin. Remaining never wraps; subtraction only occurs when remaining>=denom.
- start while busy: ignored, cambio not resampled. start in the same cycle as a done pulse (state IDLE) is accepted.
- coin_ack outside EJECT: ignored. eject_hi and eject_lo are never high simultaneously.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
1. reset, then start with cambio=5 and ack 2 cycles after each eject -> eject_hi, eject_hi, eject_lo in sequence; remaining 5->3->1->0; one GAP cycle between coins; done pulses once; busy low afterwards.
2. start with cambio=0 -> no ejects; done=1 exactly one cycle later; busy stays 0.
3. start with cambio=1, coin_ack never asserted -> eject_lo held for 15 cycles, then fault=1, eject_lo=0, remaining=1 held; further start ignored until reset clears everything.
4. start with cambio=4; during the first EJECT pulse start again with cambio=9 -> second start ignored; dispense completes with 2x eject_hi totaling 4; remaining ends at 0.
5. start with cambio=6; assert reset in the second EJECT cycle -> next cycle all outputs 0 and remaining=0; a following start with cambio=2 dispenses one eject_hi normally.
6. coin_ack pulsed while IDLE and during GAP -> no change to remaining or state; the ack that coincides with cycle 15 of EJECT is counted as success, not fault.
